a78_cart_loader: RTL and testbench



---
 rtl/a78_cart_loader_if.sv | 24 ++
 rtl/a78_cart_loader.sv | 228 ++++++++++++++++++++++
 tb/tb_a78_cart_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/a78_cart_loader_if.sv
// Download/RAM-write bus for the A78 cart loader: the hps_io ioctl stream in,
// the cart RAM port-B write strobe, address and data out.
interface a78_cart_loader_if #(
   parameter int ADDR_W = 18
) ();
   logic              ioctl_download;
   logic [7:0]        ioctl_index;
   logic              ioctl_wr;
   logic [24:0]       ioctl_addr;
   logic [7:0]        ioctl_dout;
   logic              cart_wr;
   logic [ADDR_W-1:0] cart_waddr;
   logic [7:0]        cart_wdata;

   // master: the download source (hps_io side); slave: the loader
   modport master (
      output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      input  cart_wr, cart_waddr, cart_wdata
   );
   modport slave (
      input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
      output cart_wr, cart_waddr, cart_wdata
   );
endinterface

// File: rtl/a78_cart_loader.sv
// Streaming A78/A26 cart loader: strips a signed 128-byte header, writes cart RAM, commits
// header fields on completion. Optional header size check: define A78_LOADER_SIZE_CHECK_EN.
module a78_cart_loader #(
   parameter int ADDR_W   = 18,
   parameter int HDR_LEN  = 128,
   parameter int BIOS_IDX = 0
) (
   input  logic               clk_sys,
   input  logic               reset_n,
   a78_cart_loader_if.slave   bus,
   output logic               cart_is_7800,
   output logic [15:0]        cart_flags,
   output logic [7:0]         joy0_type,
   output logic [7:0]         joy1_type,
   output logic [7:0]         cart_region,
   output logic [7:0]         cart_save,
   output logic [31:0]        cart_size,
   output logic               cart_valid,
   output logic               load_done,
   output logic               overflow,
   output logic               size_mismatch
);

   typedef enum logic [1:0] {S_IDLE, S_HDR, S_BODY, S_FINISH} state_t;

   localparam logic [24:0] HDR_LEN_A = 25'(HDR_LEN);

   state_t            state_q;
   logic              dl_q;
   logic              sig_ok_q;
   logic              sig_done_q;
   logic              any_q;
   logic [31:0]       last_addr_q;
   logic [15:0]       flags_sh_q;
   logic [7:0]        joy0_sh_q;
   logic [7:0]        joy1_sh_q;
   logic [7:0]        region_sh_q;
   logic [7:0]        save_sh_q;
   logic              cart_wr_q;
   logic [ADDR_W-1:0] cart_waddr_q;
   logic [7:0]        cart_wdata_q;
   logic              cart_is_7800_q;
   logic [15:0]       cart_flags_q;
   logic [7:0]        joy0_q;
   logic [7:0]        joy1_q;
   logic [7:0]        region_q;
   logic [7:0]        save_q;
   logic [31:0]       cart_size_q;
   logic              cart_valid_q;
   logic              load_done_q;
   logic              overflow_q;
`ifdef A78_LOADER_SIZE_CHECK_EN
   logic [31:0]       size_hdr_q;
   logic              size_mismatch_q;
`endif

   logic        cart_dl;
   logic        dl_rise;
   logic        dl_fall;
   logic        accept;
   logic        sig_valid;
   logic        sig_byte;
   logic [24:0] pay_addr;
   logic        in_range;
   logic [31:0] size_next;

   function automatic logic [7:0] sig_char(input logic [2:0] idx);
      case (idx)
         3'd1:    sig_char = 8'h41; // A
         3'd2:    sig_char = 8'h54; // T
         3'd3:    sig_char = 8'h41; // A
         3'd4:    sig_char = 8'h52; // R
         3'd5:    sig_char = 8'h49; // I
         default: sig_char = 8'h00;
      endcase
   endfunction

   assign cart_dl   = bus.ioctl_download && (bus.ioctl_index != BIOS_IDX[7:0]);
   assign dl_rise   = cart_dl && !dl_q;
   assign dl_fall   = !cart_dl && dl_q;
   assign accept    = bus.ioctl_wr && (state_q == S_HDR || state_q == S_BODY);
   // A stream that never reached byte 5 cannot claim the signature.
   assign sig_valid = sig_ok_q && sig_done_q;
   assign sig_byte  = (bus.ioctl_addr >= 25'd1) && (bus.ioctl_addr <= 25'd5);
   assign pay_addr  = (sig_valid && bus.ioctl_addr >= HDR_LEN_A) ? bus.ioctl_addr - HDR_LEN_A
                                                                 : bus.ioctl_addr;
   assign in_range  = (pay_addr >> ADDR_W) == 25'd0;
   assign size_next = any_q ? last_addr_q + 32'd1 : 32'd0;

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         // Held high so a download still in progress at reset release is not seen as a new start.
         dl_q           <= 1'b1;
         sig_ok_q       <= 1'b0;
         sig_done_q     <= 1'b0;
         any_q          <= 1'b0;
         last_addr_q    <= '0;
         flags_sh_q     <= '0;
         joy0_sh_q      <= '0;
         joy1_sh_q      <= '0;
         region_sh_q    <= '0;
         save_sh_q      <= '0;
         cart_wr_q      <= 1'b0;
         cart_waddr_q   <= '0;
         cart_wdata_q   <= '0;
         cart_is_7800_q <= 1'b0;
         cart_flags_q   <= '0;
         joy0_q         <= '0;
         joy1_q         <= '0;
         region_q       <= '0;
         save_q         <= '0;
         cart_size_q    <= '0;
         cart_valid_q   <= 1'b0;
         load_done_q    <= 1'b0;
         overflow_q     <= 1'b0;
`ifdef A78_LOADER_SIZE_CHECK_EN
         size_hdr_q      <= '0;
         size_mismatch_q <= 1'b0;
`endif
      end else begin
         dl_q        <= cart_dl;
         cart_wr_q   <= 1'b0;
         load_done_q <= 1'b0;

         if (accept) begin
            if (in_range) begin
               cart_wr_q    <= 1'b1;
               cart_waddr_q <= pay_addr[ADDR_W-1:0];
               cart_wdata_q <= bus.ioctl_dout;
            end else begin
               overflow_q <= 1'b1;
            end
            any_q       <= 1'b1;
            last_addr_q <= 32'(pay_addr);
            if (sig_byte) begin
               if (bus.ioctl_dout != sig_char(bus.ioctl_addr[2:0]))
                  sig_ok_q <= 1'b0;
               if (bus.ioctl_addr == 25'd5)
                  sig_done_q <= 1'b1;
            end
            case (bus.ioctl_addr)
`ifdef A78_LOADER_SIZE_CHECK_EN
               25'd49:  size_hdr_q[31:24] <= bus.ioctl_dout;
               25'd50:  size_hdr_q[23:16] <= bus.ioctl_dout;
               25'd51:  size_hdr_q[15:8]  <= bus.ioctl_dout;
               25'd52:  size_hdr_q[7:0]   <= bus.ioctl_dout;
`endif
               25'd53:  flags_sh_q[15:8] <= bus.ioctl_dout;
               25'd54:  flags_sh_q[7:0]  <= bus.ioctl_dout;
               25'd55:  joy0_sh_q        <= bus.ioctl_dout;
               25'd56:  joy1_sh_q        <= bus.ioctl_dout;
               25'd57:  region_sh_q      <= bus.ioctl_dout;
               25'd58:  save_sh_q        <= bus.ioctl_dout;
               default: ;
            endcase
         end

         case (state_q)
            S_IDLE: begin
               if (dl_rise) begin
                  state_q      <= S_HDR;
                  sig_ok_q     <= 1'b1;
                  sig_done_q   <= 1'b0;
                  any_q        <= 1'b0;
                  last_addr_q  <= '0;
                  cart_valid_q <= 1'b0;
                  overflow_q   <= 1'b0;
                  flags_sh_q   <= '0;
                  joy0_sh_q    <= '0;
                  joy1_sh_q    <= '0;
                  region_sh_q  <= '0;
                  save_sh_q    <= '0;
`ifdef A78_LOADER_SIZE_CHECK_EN
                  size_hdr_q      <= '0;
                  size_mismatch_q <= 1'b0;
`endif
               end
            end
            S_HDR, S_BODY: begin
               // The end of the stream wins over header completion; a byte on that edge is still taken.
               if (dl_fall) begin
                  state_q     <= S_FINISH;
                  load_done_q <= 1'b1;
               end else if (state_q == S_HDR && accept &&
                            bus.ioctl_addr >= HDR_LEN_A - 25'd1) begin
                  state_q <= S_BODY;
               end
            end
            S_FINISH: begin
               state_q        <= S_IDLE;
               cart_is_7800_q <= sig_valid;
               cart_flags_q   <= sig_valid ? flags_sh_q  : 16'd0;
               joy0_q         <= sig_valid ? joy0_sh_q   : 8'd0;
               joy1_q         <= sig_valid ? joy1_sh_q   : 8'd0;
               region_q       <= sig_valid ? region_sh_q : 8'd0;
               save_q         <= sig_valid ? save_sh_q   : 8'd0;
               cart_size_q    <= size_next;
               cart_valid_q   <= any_q && !overflow_q;
`ifdef A78_LOADER_SIZE_CHECK_EN
               size_mismatch_q <= sig_valid && (size_hdr_q != size_next);
`endif
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.cart_wr    = cart_wr_q;
   assign bus.cart_waddr = cart_waddr_q;
   assign bus.cart_wdata = cart_wdata_q;
   assign cart_is_7800   = cart_is_7800_q;
   assign cart_flags     = cart_flags_q;
   assign joy0_type      = joy0_q;
   assign joy1_type      = joy1_q;
   assign cart_region    = region_q;
   assign cart_save      = save_q;
   assign cart_size      = cart_size_q;
   assign cart_valid     = cart_valid_q;
   assign load_done      = load_done_q;
   assign overflow       = overflow_q;
`ifdef A78_LOADER_SIZE_CHECK_EN
   assign size_mismatch  = size_mismatch_q;
`else
   assign size_mismatch  = 1'b0;
`endif

endmodule

// File: tb/tb_a78_cart_loader.sv
// Bench for a78_cart_loader: streams images through the ioctl port, scoreboards RAM writes
// and checks the committed header fields after each download.
module tb_a78_cart_loader;

   localparam int TB_AW = 12;
   localparam int HL    = 128;
`ifdef A78_LOADER_SIZE_CHECK_EN
   localparam logic MM_EXP = 1'b1;
`else
   localparam logic MM_EXP = 1'b0;
`endif

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        cart_is_7800;
   logic [15:0] cart_flags;
   logic [7:0]  joy0_type;
   logic [7:0]  joy1_type;
   logic [7:0]  cart_region;
   logic [7:0]  cart_save;
   logic [31:0] cart_size;
   logic        cart_valid;
   logic        load_done;
   logic        overflow;
   logic        size_mismatch;

   a78_cart_loader_if #(.ADDR_W(TB_AW)) bus ();

   a78_cart_loader #(.ADDR_W(TB_AW), .HDR_LEN(HL), .BIOS_IDX(0)) dut (
      .clk_sys       (clk),
      .reset_n       (reset_n),
      .bus           (bus),
      .cart_is_7800  (cart_is_7800),
      .cart_flags    (cart_flags),
      .joy0_type     (joy0_type),
      .joy1_type     (joy1_type),
      .cart_region   (cart_region),
      .cart_save     (cart_save),
      .cart_size     (cart_size),
      .cart_valid    (cart_valid),
      .load_done     (load_done),
      .overflow      (overflow),
      .size_mismatch (size_mismatch)
   );

   int          n_checks = 0;
   int          n_pass   = 0;
   int          done_cnt = 0;
   logic [31:0] sb[$];
   logic [31:0] mon_exp;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", tag, got, exp);
   endtask

   // Write monitor: every RAM strobe must match the oldest expected write.
   always @(negedge clk) begin
      if (load_done) done_cnt++;
      if (bus.cart_wr) begin
         if (sb.size() == 0) begin
            check_eq("wr_unexpected", 32'({bus.cart_waddr, bus.cart_wdata}), 32'hFFFF_FFFF);
         end else begin
            mon_exp = sb.pop_front();
            check_eq("wr", 32'({bus.cart_waddr, bus.cart_wdata}), mon_exp);
         end
      end
   end

   function automatic logic [7:0] img_byte(input int a, input bit hdr, input logic [31:0] sz);
      if (a == 1) return hdr ? 8'h41 : 8'h58;
      if (hdr) begin
         case (a)
            2:  return 8'h54;
            3:  return 8'h41;
            4:  return 8'h52;
            5:  return 8'h49;
            49: return sz[31:24];
            50: return sz[23:16];
            51: return sz[15:8];
            52: return sz[7:0];
            53: return 8'h12;
            54: return 8'h34;
            55: return 8'h01;
            56: return 8'h02;
            57: return 8'h01;
            58: return 8'h03;
            default: ;
         endcase
      end
      return 8'((a * 13) ^ (a >> 7));
   endfunction

   task automatic check_zero(input string tag);
      check_eq({tag, "_is7800"}, 32'(cart_is_7800), 32'd0);
      check_eq({tag, "_flags"},  32'(cart_flags), 32'd0);
      check_eq({tag, "_types"},  32'({joy0_type, joy1_type, cart_region, cart_save}), 32'd0);
      check_eq({tag, "_size"},   cart_size, 32'd0);
      check_eq({tag, "_status"}, 32'({cart_valid, load_done, overflow, size_mismatch, bus.cart_wr}), 32'd0);
   endtask

   task automatic check_res(input string tag, input logic is78, input logic [15:0] flags,
                            input logic [31:0] types, input logic [31:0] size,
                            input logic valid, input logic ovf, input logic mm);
      check_eq({tag, "_is7800"},   32'(cart_is_7800), 32'(is78));
      check_eq({tag, "_flags"},    32'(cart_flags), 32'(flags));
      check_eq({tag, "_types"},    32'({joy0_type, joy1_type, cart_region, cart_save}), types);
      check_eq({tag, "_size"},     cart_size, size);
      check_eq({tag, "_valid"},    32'(cart_valid), 32'(valid));
      check_eq({tag, "_overflow"}, 32'(overflow), 32'(ovf));
      check_eq({tag, "_mismatch"}, 32'(size_mismatch), 32'(mm));
   endtask

   task automatic run_load(input string tag, input int n, input bit hdr, input logic [31:0] sz,
                           input logic [7:0] idx, input int abort_at, input bit drop_with_last);
      bit expect_wr = (idx != 8'd0);
      int base = done_cnt;
      int pa;
      bus.ioctl_index    = idx;
      bus.ioctl_download = 1'b1;
      @(posedge clk); #1;
      for (int a = 0; a < n; a++) begin
         if (a == abort_at) begin
            bus.ioctl_wr = 1'b0;
            @(posedge clk); #1;
            reset_n = 1'b0;
            @(posedge clk); #1;
            check_zero({tag, "_rst"});
            reset_n   = 1'b1;
            expect_wr = 1'b0;
         end
         if ($urandom_range(0, 3) == 0) begin
            bus.ioctl_wr = 1'b0;
            @(posedge clk); #1;
         end
         bus.ioctl_wr   = 1'b1;
         bus.ioctl_addr = 25'(a);
         bus.ioctl_dout = img_byte(a, hdr, sz);
         if (expect_wr) begin
            pa = (hdr && a >= HL) ? a - HL : a;
            if (pa < (1 << TB_AW)) sb.push_back(32'({pa[TB_AW-1:0], bus.ioctl_dout}));
         end
         if (drop_with_last && a == n - 1) bus.ioctl_download = 1'b0;
         @(posedge clk); #1;
      end
      bus.ioctl_wr = 1'b0;
      @(posedge clk); #1;
      bus.ioctl_download = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      check_eq({tag, "_sb_drain"}, 32'(sb.size()), 32'd0);
      sb.delete();
      check_eq({tag, "_load_done"}, 32'(done_cnt - base),
               (idx != 8'd0 && abort_at < 0) ? 32'd1 : 32'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: bench did not finish within the time limit");
      $fatal(1, "timeout");
   end

   initial begin
      reset_n            = 1'b0;
      bus.ioctl_download = 1'b0;
      bus.ioctl_index    = 8'd0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_addr     = '0;
      bus.ioctl_dout     = '0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("reset");
      reset_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;

      run_load("hdr", 4224, 1'b1, 32'h1000, 8'd1, -1, 1'b0);
      check_res("hdr", 1'b1, 16'h1234, 32'h01020103, 32'd4096, 1'b1, 1'b0, 1'b0);

      run_load("a26", 4096, 1'b0, 32'h0, 8'd2, -1, 1'b1);
      check_res("a26", 1'b0, 16'h0, 32'h0, 32'd4096, 1'b1, 1'b0, 1'b0);

      run_load("mm", 4224, 1'b1, 32'h2000, 8'd1, -1, 1'b0);
      check_res("mm", 1'b1, 16'h1234, 32'h01020103, 32'd4096, 1'b1, 1'b0, MM_EXP);

      run_load("ovf", (1 << TB_AW) + HL + 2, 1'b1, 32'd4098, 8'd1, -1, 1'b0);
      check_res("ovf", 1'b1, 16'h1234, 32'h01020103, 32'd4098, 1'b0, 1'b1, 1'b0);

      run_load("abort", 4224, 1'b1, 32'h1000, 8'd1, 300, 1'b0);
      check_zero("abort_after");

      run_load("reload", 4224, 1'b1, 32'h1000, 8'd1, -1, 1'b0);
      check_res("reload", 1'b1, 16'h1234, 32'h01020103, 32'd4096, 1'b1, 1'b0, 1'b0);

      run_load("bios", 4096, 1'b0, 32'h0, 8'd0, -1, 1'b0);
      check_res("bios", 1'b1, 16'h1234, 32'h01020103, 32'd4096, 1'b1, 1'b0, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
